pixel_streamer: RTL and testbench

//  Frame source feeding the 3x3 window collector. It reads one feature-map plane from the
//  on-chip frame buffer (1-cycle read latency) and emits it as a raster-order 8-bit pixel

---
 rtl/pixel_streamer.sv | 194 +++++++++++++++++++
 tb/tb_pixel_streamer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// pixel_streamer
//   Reads one square feature-map plane from the on-chip frame buffer and emits it
//   as a raster-order pixel stream with a valid/ready handshake. Markers travel with
//   each pixel: sof on the first pixel, eol on the last pixel of each row, and eof on
//   the last pixel of the frame.
//
//   Optional build macro: ZERO_PAD_EN
//     defined   - adds a one-pixel zero border, so the stream is (N+2)x(N+2). Border
//                 beats carry 0 and issue no memory read.
//     undefined - emits exactly NxN pixels and builds no border logic.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle pulse; starts a frame (only honoured while idle)
//   stage_width  active width = height N (sampled on an accepted start)
//   base_addr    buffer address of pixel (0,0) (sampled on an accepted start)
//   mem_rd_en    frame-buffer read strobe
//   mem_addr     frame-buffer read address
//   mem_rdata    frame-buffer read data, valid one cycle after mem_rd_en
//   pixel_out    streamed pixel
//   pixel_valid  pixel_out and markers are valid
//   pixel_ready  sink accepts the beat when valid & ready
//   sof/eol/eof  frame markers, qualified by pixel_valid
//   busy         high from the accepted start until done
//   done         one-cycle pulse after the eof beat is accepted
module pixel_streamer #(
  parameter int IMAGE_WIDTH  = 256,
  parameter int IMAGE_HEIGHT = IMAGE_WIDTH,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(IMAGE_WIDTH):0]   stage_width,
  input  logic [ADDR_W-1:0]              base_addr,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic [DATA_W-1:0]              pixel_out,
  output logic                           pixel_valid,
  input  logic                           pixel_ready,
  output logic                           sof,
  output logic                           eol,
  output logic                           eof,
  output logic                           busy,
  output logic                           done
);

  localparam int SW = $clog2(IMAGE_WIDTH) + 1;
  // One extra bit so a padded dimension (N+2) never overflows.
  localparam int CW = SW + 1;
  localparam int EW = DATA_W + 3;

  if (IMAGE_HEIGHT != IMAGE_WIDTH) begin : g_square_chk
    $error("pixel_streamer: IMAGE_HEIGHT must equal IMAGE_WIDTH");
  end
  if (ADDR_W < $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)) begin : g_addr_chk
    $error("pixel_streamer: ADDR_W too narrow for the frame");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     row_q, col_q, dim_q;
  logic [ADDR_W-1:0] addr_q;

  // Read issued last cycle; its data is on mem_rdata this cycle.
  logic              pend_q;
  logic              pend_pad_q;
  logic [2:0]        pend_mk_q;   // {sof, eol, eof}

  // Two-entry skid FIFO, entries are {data, sof, eol, eof}.
  logic [EW-1:0]     fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q;

  logic              size_ok, room, issue, border;
  logic              sof_pos, eol_pos, last_pos;
  logic              push, pop, fire;
  logic [DATA_W-1:0] byp_data;
  logic [EW-1:0]     byp_vec, out_vec;

  assign size_ok  = (stage_width != '0) && (stage_width <= SW'(IMAGE_WIDTH));
  assign sof_pos  = (row_q == '0) && (col_q == '0);
  assign eol_pos  = (col_q == dim_q - CW'(1));
  assign last_pos = eol_pos && (row_q == dim_q - CW'(1));

`ifdef ZERO_PAD_EN
  assign border = (row_q == '0) || (col_q == '0) || eol_pos || (row_q == dim_q - CW'(1));
`else
  assign border = 1'b0;
`endif

  // FIFO occupancy plus the outstanding read must stay below 2.
  assign room  = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && !pend_q);
  assign issue = (state_q == S_RUN) && room;

  assign mem_rd_en = issue && !border;
  assign mem_addr  = addr_q;

  // With an empty FIFO the returning read is presented directly; if the sink stalls
  // it is captured into the FIFO at the same edge, so the visible beat never changes.
  assign byp_data = pend_pad_q ? '0 : mem_rdata;
  assign byp_vec  = {byp_data, pend_mk_q};

  always_comb begin
    out_vec = '0;
    if (cnt_q != 2'd0) out_vec = fifo_q[rd_ptr_q];
    else if (pend_q)   out_vec = byp_vec;
  end

  assign pixel_valid = (cnt_q != 2'd0) || pend_q;
  assign pixel_out   = out_vec[EW-1:3];
  assign sof         = out_vec[2];
  assign eol         = out_vec[1];
  assign eof         = out_vec[0];

  assign fire = pixel_valid && pixel_ready;
  assign push = pend_q && !((cnt_q == 2'd0) && pixel_ready);
  assign pop  = (cnt_q != 2'd0) && pixel_ready;

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = size_ok ? S_RUN : S_DRAIN;
      S_RUN:   if (issue && last_pos) state_d = S_DRAIN;
      // An invalid size enters DRAIN with nothing in flight and falls straight through.
      S_DRAIN: if ((fire && eof) || ((cnt_q == 2'd0) && !pend_q)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      dim_q      <= '0;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      pend_pad_q <= 1'b0;
      pend_mk_q  <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        row_q  <= '0;
        col_q  <= '0;
        addr_q <= base_addr;
`ifdef ZERO_PAD_EN
        dim_q  <= CW'(stage_width) + CW'(2);
`else
        dim_q  <= CW'(stage_width);
`endif
      end

      pend_q <= issue;
      if (issue) begin
        pend_pad_q <= border;
        pend_mk_q  <= {sof_pos, eol_pos, last_pos};
        // Interior pixels are contiguous in raster order, so a running address
        // replaces base + row*N + col.
        if (!border) addr_q <= addr_q + ADDR_W'(1);
        if (eol_pos) begin
          col_q <= '0;
          row_q <= row_q + CW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= byp_vec;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
module tb_pixel_streamer;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] stage_width;
  logic [AW-1:0] base_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid;
  logic          pixel_ready;
  logic          sof, eol, eof, busy, done;

  pixel_streamer #(.IMAGE_WIDTH(256), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stage_width(stage_width),
    .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] fbuf [0:65535];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= fbuf[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat monitor, sampled on the falling edge.
  logic [10:0]   bq[$];     // {data, sof, eol, eof}
  int            bcyc[$];
  int            nreads, max_out, done_cyc;
  bit            done_seen;
  logic [AW-1:0] last_addr;
  bit            prev_stall = 1'b0;
  logic [11:0]   prev_vec   = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {pixel_valid, sof, eol, eof, pixel_out}, prev_vec);
      prev_stall = pixel_valid && !pixel_ready;
      prev_vec   = {pixel_valid, sof, eol, eof, pixel_out};
    end
    if (mem_rd_en) begin
      nreads++;
      last_addr = mem_addr;
    end
    if (nreads - bq.size() > max_out) max_out = nreads - bq.size();
    if (pixel_valid && pixel_ready) begin
      bq.push_back({pixel_out, sof, eol, eof});
      bcyc.push_back(cyc);
    end
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic clear_mon();
    bq.delete();
    bcyc.delete();
    nreads    = 0;
    max_out   = 0;
    done_seen = 1'b0;
    done_cyc  = -1;
  endtask

  task automatic run_frame(input int n, input logic [AW-1:0] base, input bit toggle,
                           input int budget, output int scyc);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; stage_width = SW'(n); base_addr = base; pixel_ready = 1'b1;
    scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; stage_width = SW'(3); base_addr = 16'h5555;
    for (int i = 0; i < budget && !done_seen; i++) begin
      @(posedge clk); #1;
      if (toggle) pixel_ready = ~pixel_ready;
    end
    pixel_ready = 1'b1;
    chk("finished", 32'(done_seen), 32'd1);
  endtask

  task automatic check_n4(input int scyc, input bit exact);
    chk("n4 beats", bq.size(), 16);
    for (int i = 0; i < bq.size(); i++) begin
      chk($sformatf("n4 beat%0d", i), 32'(bq[i]),
          {21'd0, 8'(i), 1'(i == 0), 1'(i % 4 == 3), 1'(i == 15)});
      if (exact) chk($sformatf("n4 cyc%0d", i), bcyc[i], scyc + 2 + i);
    end
    if (bq.size() > 0) chk("n4 done after eof", done_cyc, bcyc[bq.size()-1] + 1);
    if (exact) chk("n4 done cyc", done_cyc, scyc + 18);
    chk("n4 reads", nreads, 16);
  endtask

  int s;

  initial begin
    rst = 1'b1; start = 1'b0; stage_width = '0; base_addr = '0; pixel_ready = 1'b1;
    for (int i = 0; i < 65536; i++) fbuf[i] = 8'(i);
    for (int i = 0; i < 16384; i++) fbuf[16'h0100 + i] = 8'(i % 128);
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outs", {mem_rd_en, mem_addr, pixel_out, pixel_valid, sof, eol, eof, busy, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef ZERO_PAD_EN
    fbuf[16'h8000] = 8'd1; fbuf[16'h8001] = 8'd2;
    fbuf[16'h8002] = 8'd3; fbuf[16'h8003] = 8'd4;
    run_frame(2, 16'h8000, 1'b0, 60, s);
    begin
      logic [7:0] pexp [16] = '{0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0};
      chk("pad beats", bq.size(), 16);
      for (int i = 0; i < bq.size() && i < 16; i++)
        chk($sformatf("pad beat%0d", i), 32'(bq[i]),
            {21'd0, pexp[i], 1'(i == 0), 1'(i % 4 == 3), 1'(i == 15)});
      chk("pad reads", nreads, 4);
    end
`else
    // 1: N=4, ready held high.
    run_frame(4, 16'h0000, 1'b0, 60, s);
    check_n4(s, 1'b1);

    // 2: ready toggling.
    run_frame(4, 16'h0000, 1'b1, 120, s);
    check_n4(s, 1'b0);
    chk("outstanding<=2", 32'(max_out <= 2), 32'd1);

    // 3: N=128 at base 0x0100, buffer holds column index.
    run_frame(128, 16'h0100, 1'b0, 17000, s);
    chk("n128 beats", bq.size(), 16384);
    for (int i = 0; i < bq.size(); i++) begin
      chk("n128 data", 32'(bq[i][10:3]), i % 128);
      chk("n128 eol", 32'(bq[i][1]), 32'(i % 128 == 127));
    end
    chk("n128 last addr", 32'(last_addr), 32'h40FF);
    chk("n128 first cyc", bcyc[0], s + 2);
    chk("n128 eof", 32'(bq[bq.size()-1][0]), 32'd1);
    chk("n128 done cyc", done_cyc, s + 2 + 16384);

    // 4: second start mid-frame is ignored; rst while beat 7 is on the bus.
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; stage_width = SW'(4); base_addr = 16'h0000; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("busy mid", 32'(busy), 32'd1);
    start = 1'b1; stage_width = SW'(2); base_addr = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort beats", bq.size(), 8);
    for (int i = 0; i < bq.size(); i++) chk("abort data", 32'(bq[i][10:3]), i);
    chk("abort outs", {mem_rd_en, mem_addr, pixel_out, pixel_valid, sof, eol, eof, busy, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(4, 16'h0000, 1'b0, 60, s);
    check_n4(s, 1'b1);

    // 5: N=1, N=0 and oversize.
    run_frame(1, 16'h0005, 1'b0, 20, s);
    chk("n1 beats", bq.size(), 1);
    if (bq.size() > 0) begin
      chk("n1 beat", 32'(bq[0]), {21'd0, 8'd5, 3'b111});
      chk("n1 cyc", bcyc[0], s + 2);
    end
    chk("n1 done", done_cyc, s + 3);
    chk("n1 reads", nreads, 1);

    run_frame(0, 16'h0000, 1'b0, 20, s);
    chk("n0 beats", bq.size(), 0);
    chk("n0 reads", nreads, 0);
    chk("n0 done", done_cyc, s + 2);

    run_frame(300, 16'h0000, 1'b0, 20, s);
    chk("big beats", bq.size(), 0);
    chk("big reads", nreads, 0);
    chk("big done", done_cyc, s + 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
